// File: rtl/sys_defs.sv
// Shared system definitions: completion packet layout and default widths
// used by the completion/CDB stage.
package sys_defs;

  localparam int DEF_N_FU      = 5;
  localparam int DEF_CDB_WIDTH = 3;
  localparam int ROB_IDX_W     = 5;
  localparam int REG_IDX_W     = 5;
  localparam int XLEN          = 32;

  // One functional-unit result as it travels to the CDB.
  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [REG_IDX_W-1:0] dest_reg;
    logic [XLEN-1:0]      result;
    logic                 take_branch;
    logic [XLEN-1:0]      target_pc;
    logic                 halt;
    logic                 rd_mem;
    logic                 wr_mem;
  } FU_COMPLETE_PACKET;

  // Pointer width that stays legal for a single-entry configuration.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority picker: selects up to N_LANE set bits of req, scanning
// upward from start_ptr with wrap-around, and reports which request landed
// on which lane in scan order.
module rr_picker
  import sys_defs::*;
#(
  parameter int N_REQ  = DEF_N_FU,
  parameter int N_LANE = DEF_CDB_WIDTH,
  parameter int PTR_W  = ptr_width(DEF_N_FU)
) (
  input  logic [N_REQ-1:0]  req,
  input  logic [PTR_W-1:0]  start_ptr,
  output logic [N_REQ-1:0]  grant,
  output logic [PTR_W-1:0]  lane_idx [N_LANE],
  output logic [N_LANE-1:0] lane_vld,
  output logic              any_grant,
  output logic [PTR_W-1:0]  last_idx
);

  logic [2*N_REQ-1:0] req_rot2;
  logic [2*N_REQ-1:0] grant_rot2;
  logic [N_REQ-1:0]   req_rot;
  logic [N_REQ-1:0]   grant_rot;
  int                 cnt;
  int                 pos;

  // Rotate requests so scan position 0 is start_ptr, grant in order, rotate back.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path through the block leaves a value to be remembered (no latch).
    req_rot2   = {req, req} >> start_ptr;
    req_rot    = req_rot2[N_REQ-1:0];
    grant_rot  = '0;
    lane_idx   = '{default: '0};
    lane_vld   = '0;
    last_idx   = '0;
    cnt        = 0;
    pos        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_rot[k] && (cnt < N_LANE)) begin
        grant_rot[k] = 1'b1;
        pos = int'(start_ptr) + k;
        if (pos >= N_REQ) pos = pos - N_REQ;
        for (int l = 0; l < N_LANE; l++) begin
          if (cnt == l) begin
            lane_idx[l] = PTR_W'(pos);
            lane_vld[l] = 1'b1;
          end
        end
        last_idx = PTR_W'(pos);
        cnt      = cnt + 1;
      end
    end
    grant_rot2 = {grant_rot, grant_rot} << start_ptr;
    grant      = grant_rot2[2*N_REQ-1:N_REQ];
    any_grant  = |grant_rot;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Completion arbiter: merges per-FU results onto CDB_WIDTH registered
// broadcast lanes with round-robin priority. Each FU owns one hold slot that
// parks a result which lost arbitration; while the slot is full the FU is
// stalled, so every FU has at most one result in flight.
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int N_FU      = DEF_N_FU,
  parameter int CDB_WIDTH = DEF_CDB_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  logic [N_FU-1:0]   want_to_complete,
  input  FU_COMPLETE_PACKET fu_packet_in   [N_FU],
  output logic [N_FU-1:0]   complete_stall,
  output FU_COMPLETE_PACKET cdb_packet_out [CDB_WIDTH]
);

  localparam int PTR_W = ptr_width(N_FU);

  logic [N_FU-1:0]      hold_valid_q, hold_valid_d;
  FU_COMPLETE_PACKET    hold_pkt_q [N_FU];
  FU_COMPLETE_PACKET    hold_pkt_d [N_FU];
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  FU_COMPLETE_PACKET    cdb_q [CDB_WIDTH];
  FU_COMPLETE_PACKET    cdb_d [CDB_WIDTH];

  logic [N_FU-1:0]      cand_valid;
  FU_COMPLETE_PACKET    cand_pkt [N_FU];
  logic [N_FU-1:0]      grant;
  logic [PTR_W-1:0]     lane_idx [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] lane_vld;
  logic                 any_grant;
  logic [PTR_W-1:0]     last_idx;

  // Candidate per FU: a parked result wins over the live port; squash masks all.
  always_comb begin
    for (int i = 0; i < N_FU; i++) begin
      cand_valid[i] = !squash && (hold_valid_q[i] || want_to_complete[i]);
      cand_pkt[i]   = hold_valid_q[i] ? hold_pkt_q[i] : fu_packet_in[i];
    end
  end

  rr_picker #(
    .N_REQ  (N_FU),
    .N_LANE (CDB_WIDTH),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req       (cand_valid),
    .start_ptr (rr_ptr_q),
    .grant     (grant),
    .lane_idx  (lane_idx),
    .lane_vld  (lane_vld),
    .any_grant (any_grant),
    .last_idx  (last_idx)
  );

  // Next state: park losers, release winners, fill lanes, advance the pointer.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_pkt_d   = hold_pkt_q;
    rr_ptr_d     = rr_ptr_q;
    cdb_d        = '{default: '0};
    if (squash) begin
      hold_valid_d = '0;
      rr_ptr_d     = '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (cand_valid[i] && !grant[i]) begin
          hold_valid_d[i] = 1'b1;
          hold_pkt_d[i]   = cand_pkt[i];
        end else if (grant[i]) begin
          hold_valid_d[i] = 1'b0;
        end
      end
      for (int l = 0; l < CDB_WIDTH; l++) begin
        if (lane_vld[l]) begin
          for (int i = 0; i < N_FU; i++) begin
            if (lane_idx[l] == PTR_W'(i)) cdb_d[l] = cand_pkt[i];
          end
          cdb_d[l].valid = 1'b1;
        end
      end
      if (any_grant) begin
        rr_ptr_d = (last_idx == PTR_W'(N_FU - 1)) ? '0 : last_idx + PTR_W'(1);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q <= '0;
      // NOTE: the hold packets are only a few registers and are cleared too,
      // so no stale fields can ever reach the CDB after reset.
      hold_pkt_q   <= '{default: '0};
      rr_ptr_q     <= '0;
      cdb_q        <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      hold_valid_q <= hold_valid_d;
      hold_pkt_q   <= hold_pkt_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_q        <= cdb_d;
    end
  end

  assign complete_stall = hold_valid_q;
  assign cdb_packet_out = cdb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;
  import sys_defs::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              squash;
  logic [4:0]        want_to_complete;
  FU_COMPLETE_PACKET fu_packet_in   [5];
  logic [4:0]        complete_stall;
  FU_COMPLETE_PACKET cdb_packet_out [3];

  int tests_run    = 0;
  int tests_failed = 0;

  cdb_arbiter #(.N_FU(5), .CDB_WIDTH(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .squash           (squash),
    .want_to_complete (want_to_complete),
    .fu_packet_in     (fu_packet_in),
    .complete_stall   (complete_stall),
    .cdb_packet_out   (cdb_packet_out)
  );

  always #5 clock = ~clock;

  function automatic FU_COMPLETE_PACKET mk_pkt(input logic [4:0] rob);
    FU_COMPLETE_PACKET p;
    p          = '0;
    p.valid    = 1'b1;
    p.rob_idx  = rob;
    p.dest_reg = rob + 5'd1;
    p.result   = 32'hA000_0000 | {27'd0, rob};
    return p;
  endfunction

  task automatic clear_inputs();
    squash           = 1'b0;
    want_to_complete = '0;
    for (int i = 0; i < 5; i++) fu_packet_in[i] = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (complete_stall !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_stall: got %b expected %b", complete_stall, 5'b0);
    end
    for (int l = 0; l < 3; l++) begin
      tests_run++;
      if (cdb_packet_out[l] !== '0) begin
        tests_failed++;
        $display("FAIL reset_lane%0d: got %h expected 0", l, cdb_packet_out[l]);
      end
    end
    tests_run++;
    if (dut.rr_ptr_q !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr_q);
    end
  endtask

  task automatic test_single();
    do_reset();
    want_to_complete[2] = 1'b1;
    fu_packet_in[2]     = mk_pkt(5'd7);
    @(negedge clock);
    clear_inputs();
    tests_run++;
    if (cdb_packet_out[0].valid !== 1'b1 || cdb_packet_out[0].rob_idx !== 5'd7) begin
      tests_failed++;
      $display("FAIL single_lane0: got v=%b rob=%0d expected v=1 rob=7",
               cdb_packet_out[0].valid, cdb_packet_out[0].rob_idx);
    end
    tests_run++;
    if (cdb_packet_out[1].valid !== 1'b0 || cdb_packet_out[2].valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_other_lanes: got %b%b expected 00",
               cdb_packet_out[1].valid, cdb_packet_out[2].valid);
    end
    tests_run++;
    if (complete_stall !== 5'b0) begin
      tests_failed++;
      $display("FAIL single_stall: got %b expected 00000", complete_stall);
    end
    tests_run++;
    if (dut.rr_ptr_q !== 3'd3) begin
      tests_failed++;
      $display("FAIL single_rr_ptr: got %0d expected 3", dut.rr_ptr_q);
    end
    @(negedge clock);
    tests_run++;
    if (cdb_packet_out[0].valid !== 1'b0 || complete_stall !== 5'b0) begin
      tests_failed++;
      $display("FAIL single_no_dup: got v=%b stall=%b expected v=0 stall=00000",
               cdb_packet_out[0].valid, complete_stall);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    want_to_complete = 5'b11111;
    for (int i = 0; i < 5; i++) fu_packet_in[i] = mk_pkt(5'(10 + i));
    @(negedge clock);
    want_to_complete = 5'b11000;
    for (int l = 0; l < 3; l++) begin
      tests_run++;
      if (cdb_packet_out[l] !== mk_pkt(5'(10 + l))) begin
        tests_failed++;
        $display("FAIL overflow_t1_lane%0d: got %h expected %h", l,
                 cdb_packet_out[l], mk_pkt(5'(10 + l)));
      end
    end
    tests_run++;
    if (complete_stall !== 5'b11000) begin
      tests_failed++;
      $display("FAIL overflow_t1_stall: got %b expected 11000", complete_stall);
    end
    @(negedge clock);
    want_to_complete = '0;
    tests_run++;
    if (cdb_packet_out[0] !== mk_pkt(5'd13) || cdb_packet_out[1] !== mk_pkt(5'd14)) begin
      tests_failed++;
      $display("FAIL overflow_t2_lanes: got %h %h expected %h %h",
               cdb_packet_out[0], cdb_packet_out[1], mk_pkt(5'd13), mk_pkt(5'd14));
    end
    tests_run++;
    if (cdb_packet_out[2].valid !== 1'b0 || complete_stall !== 5'b0) begin
      tests_failed++;
      $display("FAIL overflow_t2_idle: got v2=%b stall=%b expected v2=0 stall=00000",
               cdb_packet_out[2].valid, complete_stall);
    end
    tests_run++;
    if (dut.rr_ptr_q !== 3'd0) begin
      tests_failed++;
      $display("FAIL overflow_rr_ptr: got %0d expected 0", dut.rr_ptr_q);
    end
    @(negedge clock);
    tests_run++;
    if ({cdb_packet_out[0].valid, cdb_packet_out[1].valid, cdb_packet_out[2].valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL overflow_t3_no_dup: got %b%b%b expected 000", cdb_packet_out[0].valid,
               cdb_packet_out[1].valid, cdb_packet_out[2].valid);
    end
  endtask

  task automatic test_fairness();
    int grants [5];
    int run    [5];
    int max_run;
    max_run = 0;
    for (int i = 0; i < 5; i++) begin
      grants[i] = 0;
      run[i]    = 0;
    end
    do_reset();
    for (int cyc = 0; cyc <= 10; cyc++) begin
      if (cyc > 0) begin
        @(negedge clock);
        for (int l = 0; l < 3; l++) begin
          if (cdb_packet_out[l].valid === 1'b1 && cdb_packet_out[l].rob_idx < 5)
            grants[cdb_packet_out[l].rob_idx]++;
        end
        for (int i = 0; i < 5; i++) begin
          if (complete_stall[i] === 1'b1) run[i]++;
          else run[i] = 0;
          if (run[i] > max_run) max_run = run[i];
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (cyc < 10) begin
          want_to_complete[i] = 1'b1;
          if (complete_stall[i] !== 1'b1) fu_packet_in[i] = mk_pkt(5'(i));
        end else begin
          want_to_complete[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (grants[i] !== 6) begin
        tests_failed++;
        $display("FAIL fairness_fu%0d_grants: got %0d expected 6", i, grants[i]);
      end
    end
    tests_run++;
    if (max_run > 1) begin
      tests_failed++;
      $display("FAIL fairness_max_wait: got %0d expected <=1", max_run);
    end
  endtask

  task automatic test_squash();
    logic leaked;
    leaked = 1'b0;
    do_reset();
    want_to_complete = 5'b01111;
    for (int i = 0; i < 5; i++) fu_packet_in[i] = mk_pkt(5'(20 + i));
    @(negedge clock);
    tests_run++;
    if (complete_stall !== 5'b01000) begin
      tests_failed++;
      $display("FAIL squash_setup_stall: got %b expected 01000", complete_stall);
    end
    squash           = 1'b1;
    want_to_complete = 5'b01001;
    fu_packet_in[0]  = mk_pkt(5'd30);
    @(negedge clock);
    clear_inputs();
    tests_run++;
    if ({cdb_packet_out[0].valid, cdb_packet_out[1].valid, cdb_packet_out[2].valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL squash_lanes: got %b%b%b expected 000", cdb_packet_out[0].valid,
               cdb_packet_out[1].valid, cdb_packet_out[2].valid);
    end
    tests_run++;
    if (complete_stall !== 5'b0) begin
      tests_failed++;
      $display("FAIL squash_stall: got %b expected 00000", complete_stall);
    end
    tests_run++;
    if (dut.rr_ptr_q !== 3'd0) begin
      tests_failed++;
      $display("FAIL squash_rr_ptr: got %0d expected 0", dut.rr_ptr_q);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      for (int l = 0; l < 3; l++) if (cdb_packet_out[l].valid !== 1'b0) leaked = 1'b1;
    end
    tests_run++;
    if (leaked !== 1'b0) begin
      tests_failed++;
      $display("FAIL squash_leak: got broadcast=%b expected 0", leaked);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    want_to_complete = 5'b11111;
    for (int i = 0; i < 5; i++) fu_packet_in[i] = mk_pkt(5'(40 + i));
    @(negedge clock);
    want_to_complete = 5'b11000;
    tests_run++;
    if (complete_stall !== 5'b11000) begin
      tests_failed++;
      $display("FAIL areset_setup_stall: got %b expected 11000", complete_stall);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (complete_stall !== 5'b0 || dut.rr_ptr_q !== 3'd0) begin
      tests_failed++;
      $display("FAIL areset_state: got stall=%b rr=%0d expected 00000/0",
               complete_stall, dut.rr_ptr_q);
    end
    tests_run++;
    if (cdb_packet_out[0] !== '0 || cdb_packet_out[1] !== '0 || cdb_packet_out[2] !== '0) begin
      tests_failed++;
      $display("FAIL areset_lanes: got %h %h %h expected all 0", cdb_packet_out[0],
               cdb_packet_out[1], cdb_packet_out[2]);
    end
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    want_to_complete[1] = 1'b1;
    fu_packet_in[1]     = mk_pkt(5'd50);
    @(negedge clock);
    clear_inputs();
    tests_run++;
    if (cdb_packet_out[0] !== mk_pkt(5'd50) || cdb_packet_out[1].valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_after_release: got %h v1=%b expected %h v1=0",
               cdb_packet_out[0], cdb_packet_out[1].valid, mk_pkt(5'd50));
    end
  endtask

  task automatic test_passthrough();
    FU_COMPLETE_PACKET br_pkt;
    FU_COMPLETE_PACKET halt_pkt;
    br_pkt             = mk_pkt(5'd1);
    br_pkt.take_branch = 1'b1;
    br_pkt.target_pc   = 32'h0000_1000;
    br_pkt.wr_mem      = 1'b1;
    halt_pkt           = mk_pkt(5'd4);
    halt_pkt.halt      = 1'b1;
    halt_pkt.rd_mem    = 1'b1;
    do_reset();
    want_to_complete = 5'b10001;
    fu_packet_in[0]  = br_pkt;
    fu_packet_in[4]  = halt_pkt;
    @(negedge clock);
    clear_inputs();
    tests_run++;
    if (cdb_packet_out[0] !== br_pkt) begin
      tests_failed++;
      $display("FAIL pass_branch_lane0: got %h expected %h", cdb_packet_out[0], br_pkt);
    end
    tests_run++;
    if (cdb_packet_out[1] !== halt_pkt) begin
      tests_failed++;
      $display("FAIL pass_halt_lane1: got %h expected %h", cdb_packet_out[1], halt_pkt);
    end
    tests_run++;
    if (cdb_packet_out[2].valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL pass_lane2: got v=%b expected 0", cdb_packet_out[2].valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    @(negedge clock);
    test_reset();
    reset = 1'b0;
    test_single();
    test_overflow();
    test_fairness();
    test_squash();
    test_async_reset();
    test_passthrough();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter N_FU, default 5, number of functional-unit complete ports.
REQ-002 The block SHALL have parameter CDB_WIDTH, default 3, number of CDB broadcast lanes per cycle.
REQ-003 Port clock  input  1  single clock for all state.
REQ-004 Port reset  input  1  asynchronous active-high reset.
REQ-005 Port squash  input  1  branch-mispredict flush; discards all pending completions.
REQ-006 Port want_to_complete  input  [N_FU]  per-FU completion request.
REQ-007 Port fu_packet_in  input  FU_COMPLETE_PACKET [N_FU]  per-FU result packet.
REQ-008 Port complete_stall  output  [N_FU]  per-FU back-pressure; the FU holds its output while this is high.
REQ-009 Port cdb_packet_out  output  FU_COMPLETE_PACKET [CDB_WIDTH]  registered CDB lanes; lane valid field qualifies each lane.

Function
REQ-010 Each FU i SHALL own one hold register: hold_valid[i] plus a packet.
REQ-011 The candidate for FU i SHALL be hold[i] if hold_valid[i]=1, else fu_packet_in[i] if want_to_complete[i]=1, else none.
REQ-012 While complete_stall[i]=1, fu_packet_in[i] and want_to_complete[i] SHALL be ignored.
REQ-013 complete_stall[i] SHALL equal hold_valid[i] and be driven from state only, with no combinational path from inputs.
REQ-014 Up to CDB_WIDTH candidates SHALL be granted per cycle, scanning FU indices from rr_ptr upward modulo N_FU.
REQ-015 Granted packets SHALL appear on cdb_packet_out lanes 0..k-1 in scan order on the next clock edge, giving 1-cycle latency; lanes k..CDB_WIDTH-1 SHALL have valid=0.
REQ-016 An ungranted input candidate SHALL be written into hold[i]; an ungranted hold SHALL keep its value; a granted hold SHALL clear.
REQ-017 rr_ptr SHALL advance to (last granted index + 1) mod N_FU when at least one grant occurs, and SHALL stay unchanged otherwise.
REQ-018 Packet fields, including halt, rd_mem, wr_mem, take_branch and target_pc, SHALL pass through unmodified.
REQ-019 When squash=1, the block SHALL issue no grants that cycle, clear all hold_valid on the next edge, drive all cdb lane valids to 0 on the next edge, and set rr_ptr to 0.
REQ-020 If N_FU candidates are at most CDB_WIDTH, all SHALL be granted and nothing held.
REQ-021 Each FU SHALL have at most one packet in flight; no packet SHALL be dropped or duplicated absent squash.

Reset
REQ-022 On reset assertion, asynchronously: hold_valid all 0, hold packets all 0, rr_ptr 0, cdb_packet_out all fields 0.
REQ-023 complete_stall SHALL be all 0 during and immediately after reset.
REQ-024 Reset deasserted mid-traffic SHALL leave the block accepting inputs on the first rising edge.

Structure
REQ-025 FU_COMPLETE_PACKET and the CDB_WIDTH and N_FU defaults SHALL live in the shared sys_defs package; no local packet typedefs.
REQ-026 The block SHALL have one sub-module, rr_picker: combinational rotating-priority select of up to CDB_WIDTH requests from an N_FU-bit vector and a start pointer, returning grant mask and lane mapping.
REQ-027 The total RTL SHALL be about 150-250 lines; rr_ptr width SHALL be $clog2(N_FU).

Verification
REQ-028 Single request: FU2 presents at cycle t with rob_idx=7 -> lane0 valid, rob_idx=7 at t+1; complete_stall never asserted; rr_ptr=3.
REQ-029 Overflow: all 5 FUs request at t with rr_ptr=0 -> FU0,1,2 on lanes 0-2 at t+1; complete_stall[3],[4]=1 at t+1; FU3,4 on lanes 0-1 at t+2; stalls drop at t+2.
REQ-030 Fairness: FUs 0-4 request every cycle for 10 cycles -> each FU is granted 6 times and no FU waits more than 1 cycle.
REQ-031 Squash: hold_valid[3]=1, squash at t -> cdb lanes invalid at t+1, complete_stall all 0 at t+1, rr_ptr=0, and the held packet is never broadcast.
REQ-032 Async reset: assert reset mid-cycle with 2 holds pending -> outputs go to 0 before the next edge; after release, a new FU1 request appears on lane0 one cycle later.
REQ-033 Pass-through: FU0 sends a branch packet with take_branch=1 and target_pc=0x1000, and FU4 sends halt=1 in the same cycle -> both appear unmodified at t+1 on lanes 0 and 1.
